// File: rtl/spi_target.sv
`timescale 1ns/1ps
// spi_target: SPI mode-0 target (MSB first, full duplex). It oversamples the SPI pins on clk_48mhz
// and exchanges whole bytes with user logic.
// Latency: every pin event acts SYNC_STAGES+1 clk_48mhz cycles after the pin edge.
// Backpressure: rx has none, so user logic must take every rx_valid. tx uses a one-entry holding
// register with a valid/ready handshake, and IDLE_BYTE is sent when that register is empty.
// Ports: clk_48mhz/reset (async, active high); spi_sck/spi_cs_n/spi_mosi/spi_miso/spi_miso_oe pins;
// rx_data/rx_valid receive strobe; tx_data/tx_valid/tx_ready transmit handshake;
// tx_underrun/frame_start/frame_end event strobes.
// Optional: define SPI_TARGET_BYTECOUNT_EN to add rx_count[15:0], the number of bytes received in the frame.
module spi_target #(
  parameter int unsigned SYNC_STAGES = 2,      // legal 2..3
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       frame_start,
  output logic       frame_end
`ifdef SPI_TARGET_BYTECOUNT_EN
  ,
  output logic [15:0] rx_count
`endif
);

  localparam int unsigned TOP = SYNC_STAGES - 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_prev, cs_prev;
  logic       sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift;
  logic [7:0] hold_data;
  logic       hold_full;

  logic       start_frame, end_frame, sample, load_tx, shift_tx;
  logic [7:0] load_val;

  // The synchroniser chains and their previous copies reset to 0. That includes cs_n.
  // If the host keeps cs_n low across a reset, no falling edge is seen afterwards, so no frame
  // starts until the host deselects and selects again. A rising edge seen while idle is ignored.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      end
      sck_prev <= sck_sync[TOP];
      cs_prev  <= cs_sync[TOP];
    end
  end

  assign sck_rise = sck_sync[TOP] & ~sck_prev;
  assign sck_fall = ~sck_sync[TOP] & sck_prev;
  assign cs_fall  = ~cs_sync[TOP] & cs_prev;
  assign cs_rise  = cs_sync[TOP] & ~cs_prev;
  assign mosi_s   = mosi_sync[TOP];

  // State register.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (cs_fall) state_next = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Per-cycle actions. A cs_n rise takes priority over an sck edge in the same cycle.
  always_comb begin
    start_frame = 1'b0;
    end_frame   = 1'b0;
    sample      = 1'b0;
    shift_tx    = 1'b0;
    load_tx     = 1'b0;
    case (state)
      ST_IDLE: begin
        start_frame = cs_fall;
        load_tx     = cs_fall;
      end
      ST_ACTIVE: begin
        end_frame = cs_rise;
        sample    = ~cs_rise & sck_rise;
        load_tx   = ~cs_rise & sck_fall & (bit_cnt == 3'd0);
        shift_tx  = ~cs_rise & sck_fall & (bit_cnt != 3'd0);
      end
      default: ;
    endcase
  end

  assign load_val = hold_full ? hold_data : IDLE_BYTE;
  assign tx_ready = ~hold_full;

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      hold_data   <= 8'h00;
      hold_full   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_start <= start_frame;
      frame_end   <= end_frame;

      if (start_frame) begin
        bit_cnt     <= 3'd0;
        spi_miso_oe <= 1'b1;
      end
      if (end_frame) begin
        bit_cnt     <= 3'd0;
        spi_miso_oe <= 1'b0;
      end

      // MISO is registered together with the shift register, so the pin always shows the new bit 7.
      if (load_tx) begin
        tx_shift    <= load_val;
        spi_miso    <= load_val[7];
        tx_underrun <= ~hold_full;
      end else if (shift_tx) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
        spi_miso <= tx_shift[6];
      end

      if (sample) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data  <= {rx_shift[6:0], mosi_s};
          rx_valid <= 1'b1;
        end
      end

      // A consume needs a full register and a write needs an empty one, so they never collide.
      if (load_tx && hold_full) begin
        hold_full <= 1'b0;
      end else if (tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end
    end
  end

`ifdef SPI_TARGET_BYTECOUNT_EN
  // Bytes received in the current frame. The count saturates and stays readable after frame_end.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      rx_count <= 16'h0000;
    end else if (start_frame) begin
      rx_count <= 16'h0000;
    end else if (sample && (bit_cnt == 3'd7) && (rx_count != 16'hFFFF)) begin
      rx_count <= rx_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_target.sv
`timescale 1ns/1ps
// tb_spi_target: directed bench for spi_target. It plays an SPI mode-0 host with sck at 1/12 of
// clk_48mhz and checks the user-side strobes and data against hand-computed values.
module tb_spi_target;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       spi_sck   = 1'b0;
  logic       spi_cs_n  = 1'b1;
  logic       spi_mosi  = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_ready, tx_underrun, frame_start, frame_end;
`ifdef SPI_TARGET_BYTECOUNT_EN
  logic [15:0] rx_count;
`endif

  int total = 0;
  int bad   = 0;
  int n_rxv = 0, n_und = 0, n_fs = 0, n_fe = 0;
  int s_rxv, s_und, s_fs, s_fe;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] m1, m2;

  spi_target dut (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .frame_start(frame_start),
    .frame_end  (frame_end)
`ifdef SPI_TARGET_BYTECOUNT_EN
    ,
    .rx_count   (rx_count)
`endif
  );

  always #10 clk_48mhz = ~clk_48mhz;

  // Count strobe cycles on the falling edge, away from the DUT's active edge.
  always @(negedge clk_48mhz) begin
    if (rx_valid) begin
      n_rxv   = n_rxv + 1;
      last_rx = rx_data;
    end
    if (tx_underrun) n_und = n_und + 1;
    if (frame_start) n_fs = n_fs + 1;
    if (frame_end)   n_fe = n_fe + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  task automatic snap();
    s_rxv = n_rxv;
    s_und = n_und;
    s_fs  = n_fs;
    s_fe  = n_fe;
  endtask

  task automatic select_target();
    spi_cs_n = 1'b0;
    clks(8);
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    clks(1);
    tx_valid = 1'b0;
  endtask

  // Send the top n bits of mo and sample MISO at each rising sck edge. When last is set, cs_n rises
  // together with the final sck fall, so the target must give the deselect priority.
  task automatic spi_bits(input logic [7:0] mo, input int n, input bit last, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = mo[i];
      clks(6);
      spi_sck = 1'b1;
      mi[i]   = spi_miso;
      clks(6);
      if (last && i == 8 - n) spi_cs_n = 1'b1;
      spi_sck = 1'b0;
    end
  endtask

  initial begin
    // Reset values
    clks(5);
    check("rst_miso",   32'(spi_miso),    32'h0);
    check("rst_oe",     32'(spi_miso_oe), 32'h0);
    check("rst_rxdata", 32'(rx_data),     32'h0);
    check("rst_rxv",    32'(rx_valid),    32'h0);
    check("rst_txrdy",  32'(tx_ready),    32'h1);
    check("rst_und",    32'(tx_underrun), 32'h0);
    check("rst_fs",     32'(frame_start), 32'h0);
    check("rst_fe",     32'(frame_end),   32'h0);
    reset = 1'b0;
    clks(5);

    // A preloaded byte goes out while 3C comes in.
    tx_write(8'hA5);
    check("b_txrdy_full", 32'(tx_ready), 32'h0);
    snap();
    select_target();
    check("b_txrdy_back", 32'(tx_ready), 32'h1);
    check("b_oe_on",      32'(spi_miso_oe), 32'h1);
    check("b_fs",         32'(n_fs - s_fs), 32'd1);
    check("b_miso_msb",   32'(spi_miso), 32'h1);
    spi_bits(8'h3C, 8, 1'b1, m1);
    clks(8);
    check("b_miso_byte",  32'(m1), 32'hA5);
    check("b_rxv",        32'(n_rxv - s_rxv), 32'd1);
    check("b_rxdata",     32'(last_rx), 32'h3C);
    check("b_und",        32'(n_und - s_und), 32'd0);
    check("b_fe",         32'(n_fe - s_fe), 32'd1);
    check("b_oe_off",     32'(spi_miso_oe), 32'h0);

    // Nothing is preloaded for a 2-byte frame, so IDLE_BYTE is sent twice.
    snap();
    select_target();
    spi_bits(8'h5A, 8, 1'b0, m1);
    spi_bits(8'hC3, 8, 1'b1, m2);
    clks(8);
    check("c_miso0", 32'(m1), 32'hFF);
    check("c_miso1", 32'(m2), 32'hFF);
    check("c_und",   32'(n_und - s_und), 32'd2);
    check("c_rxv",   32'(n_rxv - s_rxv), 32'd2);
    check("c_rxdata", 32'(last_rx), 32'hC3);

    // Reset arrives mid-frame, after 3 bits, with a byte waiting in the holding register.
    select_target();
    spi_bits(8'hE0, 3, 1'b0, m1);
    tx_write(8'h77);
    check("r_txrdy_pre", 32'(tx_ready), 32'h0);
    check("r_oe_pre",    32'(spi_miso_oe), 32'h1);
    reset = 1'b1;
    #1;
    check("r_oe",     32'(spi_miso_oe), 32'h0);
    check("r_miso",   32'(spi_miso),    32'h0);
    check("r_rxdata", 32'(rx_data),     32'h0);
    check("r_txrdy",  32'(tx_ready),    32'h1);
    clks(3);
    reset = 1'b0;
    clks(4);
    snap();
    spi_bits(8'hFF, 8, 1'b1, m1);
    clks(8);
    check("r_no_rxv", 32'(n_rxv - s_rxv), 32'd0);
    check("r_no_fs",  32'(n_fs - s_fs),   32'd0);

    // The frame is aborted after 5 bits. The next frame must start again at bit 0.
    snap();
    select_target();
    check("d_und_start", 32'(n_und - s_und), 32'd1);
    spi_bits(8'hFF, 5, 1'b1, m1);
    clks(8);
    check("d_fe",     32'(n_fe - s_fe),   32'd1);
    check("d_no_rxv", 32'(n_rxv - s_rxv), 32'd0);
    check("d_oe_off", 32'(spi_miso_oe),   32'h0);
    snap();
    select_target();
    spi_bits(8'h81, 8, 1'b1, m1);
    clks(8);
    check("d_rxv",    32'(n_rxv - s_rxv), 32'd1);
    check("d_rxdata", 32'(last_rx), 32'h81);

    // Back-to-back bytes. The second is written once the first has been consumed.
    tx_write(8'h11);
    snap();
    select_target();
    check("e_txrdy_free", 32'(tx_ready), 32'h1);
    tx_write(8'h22);
    check("e_txrdy_full", 32'(tx_ready), 32'h0);
    spi_bits(8'hAA, 8, 1'b0, m1);
    spi_bits(8'h55, 8, 1'b1, m2);
    clks(8);
    check("e_miso0",  32'(m1), 32'h11);
    check("e_miso1",  32'(m2), 32'h22);
    check("e_und",    32'(n_und - s_und), 32'd0);
    check("e_rxv",    32'(n_rxv - s_rxv), 32'd2);
    check("e_rxdata", 32'(last_rx), 32'h55);
    check("e_txrdy",  32'(tx_ready), 32'h1);

`ifdef SPI_TARGET_BYTECOUNT_EN
    // Byte count over a 3-byte frame, then cleared by the next frame_start.
    check("f_hold_prev", 32'(rx_count), 32'd2);
    select_target();
    check("f_cnt0", 32'(rx_count), 32'd0);
    spi_bits(8'h01, 8, 1'b0, m1);
    check("f_cnt1", 32'(rx_count), 32'd1);
    spi_bits(8'h02, 8, 1'b0, m1);
    check("f_cnt2", 32'(rx_count), 32'd2);
    spi_bits(8'h03, 8, 1'b1, m1);
    check("f_cnt3", 32'(rx_count), 32'd3);
    clks(8);
    check("f_hold", 32'(rx_count), 32'd3);
    select_target();
    check("f_clear", 32'(rx_count), 32'd0);
    spi_bits(8'h04, 8, 1'b1, m1);
    clks(8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 target (peripheral) that lets an external host MCU talk to the FPGA design.
- It is the responder counterpart to the bootloader's SPI flash initiator.
- Pins are oversampled on clk_48mhz and exchanged as bytes with user logic: a receive strobe plus a single-entry transmit holding register with valid/ready handshake.
- MSB first; full-duplex.

Parameters:
SYNC_STAGES  2  flip-flop depth of input synchronisers on spi_sck, spi_cs_n, spi_mosi (legal 2..3)
IDLE_BYTE  8'hFF  byte shifted out when no transmit byte is available at a byte boundary

Ports:
clk_48mhz  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
spi_sck  input  1  SPI clock from host, idle low; max 6 MHz
spi_cs_n  input  1  chip select from host, active low
spi_mosi  input  1  host-to-target data
spi_miso  output  1  target-to-host data
spi_miso_oe  output  1  output enable for MISO pad; high only while selected
rx_data  output  8  last fully received byte
rx_valid  output  1  one-cycle strobe: rx_data updated
tx_data  input  8  next byte to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding register empty; transfer occurs when tx_valid && tx_ready
tx_underrun  output  1  one-cycle strobe: IDLE_BYTE substituted at a byte boundary
frame_start  output  1  one-cycle strobe on synchronised cs_n falling edge
frame_end  output  1  one-cycle strobe on synchronised cs_n rising edge

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, frame_start=0, frame_end=0. Reset also clears bit counter, shift registers, holding register and state.
- Sync/edge detection: inputs pass SYNC_STAGES flops; edges are detected by comparing against one further registered copy. All events act SYNC_STAGES+1 cycles after the pin edge.
- States: IDLE (cs_n high), ACTIVE (cs_n low).
- IDLE -> ACTIVE on cs_n fall:
  - frame_start pulses; bit_cnt=0; spi_miso_oe=1.
  - Load tx shift register from the holding register if full (holding becomes empty, tx_ready=1 next cycle); otherwise load IDLE_BYTE and pulse tx_underrun.
  - spi_miso = tx_shift[7] in the same cycle as the load.
- ACTIVE, sck rising edge: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt increments (3 bits, wraps 7->0). When bit_cnt was 7: rx_data <= assembled byte and rx_valid pulses the same cycle rx_data updates.
- ACTIVE, sck falling edge:
  - bit_cnt==0 (byte boundary): reload tx_shift by the same rule as frame start.
  - Otherwise: tx_shift shifts left by one.
  - spi_miso always follows tx_shift[7].
- ACTIVE -> IDLE on cs_n rise:
  - frame_end pulses; spi_miso_oe=0; bit_cnt=0.
  - A partial received byte is discarded: no rx_valid. A partially sent tx byte is dropped, not re-queued.
  - cs_n rise has priority over a coincident sck edge.
- Holding register:
  - One entry; tx_ready = !full; persists across frames.
  - Write and consume cannot coincide: a write needs empty, a consume needs full. A consume while empty is an underrun.
- sck edges while IDLE are ignored. rx_valid carries no backpressure; user logic must take every byte.
- Timing: sck high and low times must each be >= 4 clk_48mhz cycles.

Optional Feature:
- Macro SPI_TARGET_BYTECOUNT_EN.
- Defined: adds output rx_count[15:0], the number of complete bytes received in the current frame. Cleared to 0 on frame_start and reset; increments with each rx_valid; saturates at 16'hFFFF; holds its value after frame_end until the next frame_start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset asserted mid-frame (cs_n low, 3 bits shifted) -> all outputs take reset values at once; after release with cs_n held low, no rx_valid occurs until a new cs_n fall.
- tx_data=8'hA5 written before select, host clocks 8 bits of MOSI 8'h3C at 4 MHz -> host samples MISO 8'hA5; rx_valid once with rx_data=8'h3C; tx_ready returns to 1 after frame_start.
- No tx byte loaded, 2-byte frame -> MISO 8'hFF,8'hFF; tx_underrun pulses twice (frame start and byte boundary); two rx_valid.
- cs_n raised after 5 bits -> frame_end pulse, no rx_valid, spi_miso_oe=0; next frame receives 8'h81 correctly aligned.
- Back-to-back bytes 8'h11,8'h22 loaded via handshake during the frame (second written after first consumed) -> MISO 8'h11,8'h22; no underrun.
- With SPI_TARGET_BYTECOUNT_EN, 3-byte frame then new frame -> rx_count 1,2,3, holds 3 after frame_end, returns to 0 at the next frame_start.
